// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: arbitrates at instruction boundaries, then drives Cause/EPC writes, PC redirect and eret.
// Latency: Cause/EPC write pulse 1 cycle after the deciding boundary, PC write 2 cycles after it; eret PC write 1 cycle after.
// Backpressure: stall holds the main control FSM while a sequence runs; boundary is ignored until it drops.
module cp0_exc_ctrl #(
    parameter logic [31:0] VECTOR_ADDR = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_req,
    input  logic        boundary,
    input  logic        exc_ovf,
    input  logic        exc_unimpl,
    input  logic        exc_sys,
    input  logic        eret,
    input  logic [31:0] cur_pc,
    input  logic [31:0] next_pc,
    input  logic [31:0] epc_q,
    input  logic        sts_we,
    input  logic [1:0]  sts_wdata,
    output logic [1:0]  cause_code,
    output logic        cause_we,
    output logic        epc_we,
    output logic [31:0] epc_wdata,
    output logic        pc_we,
    output logic [31:0] pc_wdata,
    output logic        stall,
    output logic        ie,
    output logic        exl
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAVE   = 2'd1,
        VECTOR = 2'd2,
        RET    = 2'd3
    } state_t;

    localparam logic [1:0] CODE_INT    = 2'b00;
    localparam logic [1:0] CODE_SYS    = 2'b01;
    localparam logic [1:0] CODE_UNIMPL = 2'b10;
    localparam logic [1:0] CODE_OVF    = 2'b11;

    state_t      state, state_d;
    logic        int_pend, int_pend_d;
    logic [1:0]  cause_code_d;
    logic        cause_we_d, epc_we_d, pc_we_d, stall_d, ie_d, exl_d;
    logic [31:0] epc_wdata_d, pc_wdata_d;
    logic        take_int;

    assign take_int = int_pend & ie & ~exl;

    always_comb begin
        state_d      = state;
        int_pend_d   = int_pend | int_req;
        cause_code_d = cause_code;
        epc_wdata_d  = epc_wdata;
        pc_wdata_d   = pc_wdata;
        cause_we_d   = 1'b0;
        epc_we_d     = 1'b0;
        pc_we_d      = 1'b0;
        stall_d      = 1'b0;
        ie_d         = ie;
        exl_d        = exl;

        case (state)
            IDLE: begin
                if (sts_we) begin
                    ie_d  = sts_wdata[0];
                    exl_d = sts_wdata[1];
                end
                if (boundary) begin
                    // Outputs are registered, so the SAVE/RET pulses are launched on the deciding edge.
                    if (exc_ovf || exc_unimpl || exc_sys || take_int) begin
                        state_d     = SAVE;
                        cause_we_d  = 1'b1;
                        epc_we_d    = 1'b1;
                        stall_d     = 1'b1;
                        epc_wdata_d = cur_pc;
                        if (exc_ovf)         cause_code_d = CODE_OVF;
                        else if (exc_unimpl) cause_code_d = CODE_UNIMPL;
                        else if (exc_sys)    cause_code_d = CODE_SYS;
                        else begin
                            cause_code_d = CODE_INT;
                            epc_wdata_d  = next_pc;
                        end
                    end else if (eret) begin
                        state_d    = RET;
                        pc_we_d    = 1'b1;
                        pc_wdata_d = epc_q;
                        stall_d    = 1'b1;
                    end
                end
            end
            SAVE: begin
                state_d    = VECTOR;
                exl_d      = 1'b1;
                pc_we_d    = 1'b1;
                pc_wdata_d = VECTOR_ADDR;
                stall_d    = 1'b1;
                if (cause_code == CODE_INT) int_pend_d = 1'b0;
            end
            VECTOR: state_d = IDLE;
            RET: begin
                state_d = IDLE;
                exl_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            int_pend   <= 1'b0;
            cause_code <= 2'b00;
            epc_wdata  <= 32'd0;
            pc_wdata   <= 32'd0;
            cause_we   <= 1'b0;
            epc_we     <= 1'b0;
            pc_we      <= 1'b0;
            stall      <= 1'b0;
            ie         <= 1'b0;
            exl        <= 1'b0;
        end else begin
            state      <= state_d;
            int_pend   <= int_pend_d;
            cause_code <= cause_code_d;
            epc_wdata  <= epc_wdata_d;
            pc_wdata   <= pc_wdata_d;
            cause_we   <= cause_we_d;
            epc_we     <= epc_we_d;
            pc_we      <= pc_we_d;
            stall      <= stall_d;
            ie         <= ie_d;
            exl        <= exl_d;
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: one task per scenario with hand-computed expectations.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        int_req, boundary, exc_ovf, exc_unimpl, exc_sys, eret, sts_we;
    logic [31:0] cur_pc, next_pc, epc_q;
    logic [1:0]  sts_wdata;
    logic [1:0]  cause_code;
    logic        cause_we, epc_we, pc_we, stall, ie, exl;
    logic [31:0] epc_wdata, pc_wdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl #(.VECTOR_ADDR(32'h0000_0008)) dut (
        .clk(clk), .rst(rst), .int_req(int_req), .boundary(boundary),
        .exc_ovf(exc_ovf), .exc_unimpl(exc_unimpl), .exc_sys(exc_sys), .eret(eret),
        .cur_pc(cur_pc), .next_pc(next_pc), .epc_q(epc_q),
        .sts_we(sts_we), .sts_wdata(sts_wdata),
        .cause_code(cause_code), .cause_we(cause_we), .epc_we(epc_we), .epc_wdata(epc_wdata),
        .pc_we(pc_we), .pc_wdata(pc_wdata), .stall(stall), .ie(ie), .exl(exl)
    );

    // Advance one edge and settle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        int_req = 0; boundary = 0; exc_ovf = 0; exc_unimpl = 0; exc_sys = 0; eret = 0;
        sts_we = 0; sts_wdata = 2'b00;
    endtask

    task automatic test_reset();
        idle_inputs();
        cur_pc = 32'h0; next_pc = 32'h0; epc_q = 32'h0;
        rst = 1;
        step(); step();
        rst = 0;
        checks++; if ({cause_we, epc_we, pc_we, stall} !== 4'b0000) begin failures++; $display("FAIL reset_enables got=%b exp=0000", {cause_we, epc_we, pc_we, stall}); end
        checks++; if ({ie, exl, cause_code} !== 4'b0000) begin failures++; $display("FAIL reset_status got=%b exp=0000", {ie, exl, cause_code}); end
        checks++; if (epc_wdata !== 32'h0 || pc_wdata !== 32'h0) begin failures++; $display("FAIL reset_data got epc=%h pc=%h exp=0/0", epc_wdata, pc_wdata); end
        checks++; if (dut.int_pend !== 1'b0) begin failures++; $display("FAIL reset_int_pend got=%b exp=0", dut.int_pend); end
    endtask

    task automatic test_interrupt();
        sts_we = 1; sts_wdata = 2'b01;
        step();
        sts_we = 0;
        checks++; if (ie !== 1'b1 || exl !== 1'b0) begin failures++; $display("FAIL sts_write got ie=%b exl=%b exp=1/0", ie, exl); end
        int_req = 1; step(); int_req = 0;
        boundary = 1; next_pc = 32'h40; cur_pc = 32'h3c;
        step();
        boundary = 0;
        checks++; if ({cause_we, epc_we, pc_we, stall} !== 4'b1101) begin failures++; $display("FAIL int_save got=%b exp=1101", {cause_we, epc_we, pc_we, stall}); end
        checks++; if (cause_code !== 2'b00 || epc_wdata !== 32'h40) begin failures++; $display("FAIL int_cause got code=%b epc=%h exp=00/40", cause_code, epc_wdata); end
        step();
        checks++; if ({cause_we, epc_we, pc_we, stall} !== 4'b0011 || pc_wdata !== 32'h8) begin failures++; $display("FAIL int_vector got=%b pc=%h exp=0011/8", {cause_we, epc_we, pc_we, stall}, pc_wdata); end
        checks++; if (exl !== 1'b1 || dut.int_pend !== 1'b0) begin failures++; $display("FAIL int_exl_pend got exl=%b pend=%b exp=1/0", exl, dut.int_pend); end
        step();
        checks++; if ({cause_we, epc_we, pc_we, stall} !== 4'b0000) begin failures++; $display("FAIL int_done got=%b exp=0000", {cause_we, epc_we, pc_we, stall}); end
    endtask

    task automatic test_priority();
        int cause_pulses = 0;
        int_req = 1; step(); int_req = 0;
        exc_ovf = 1; exc_sys = 1; boundary = 1; cur_pc = 32'h24; next_pc = 32'h28;
        step();
        exc_ovf = 0; exc_sys = 0; boundary = 0;
        checks++; if (cause_we !== 1'b1 || cause_code !== 2'b11 || epc_wdata !== 32'h24) begin failures++; $display("FAIL prio_cause got we=%b code=%b epc=%h exp=1/11/24", cause_we, cause_code, epc_wdata); end
        for (int i = 0; i < 4; i++) begin
            if (cause_we) cause_pulses++;
            step();
        end
        checks++; if (cause_pulses != 1) begin failures++; $display("FAIL prio_single_seq got pulses=%0d exp=1", cause_pulses); end
        checks++; if (dut.int_pend !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL prio_pend_kept got pend=%b stall=%b exp=1/0", dut.int_pend, stall); end
    endtask

    task automatic test_masked_then_eret();
        // exl=1 from the previous sequence masks the pending interrupt.
        int_req = 1; boundary = 1; next_pc = 32'h48;
        step();
        boundary = 0;
        checks++; if (stall !== 1'b0 || cause_we !== 1'b0) begin failures++; $display("FAIL exl_masks got stall=%b cause_we=%b exp=0/0", stall, cause_we); end
        eret = 1; epc_q = 32'h44; boundary = 1;
        step();
        eret = 0; boundary = 0;
        checks++; if ({cause_we, pc_we, stall} !== 3'b011 || pc_wdata !== 32'h44 || exl !== 1'b1) begin failures++; $display("FAIL eret_pc got=%b pc=%h exl=%b exp=011/44/1", {cause_we, pc_we, stall}, pc_wdata, exl); end
        step();
        checks++; if (exl !== 1'b0 || pc_we !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL eret_done got exl=%b pc_we=%b stall=%b exp=0/0/0", exl, pc_we, stall); end
        boundary = 1;
        step();
        boundary = 0; int_req = 0;
        checks++; if (cause_we !== 1'b1 || cause_code !== 2'b00 || epc_wdata !== 32'h48) begin failures++; $display("FAIL int_after_eret got we=%b code=%b epc=%h exp=1/00/48", cause_we, cause_code, epc_wdata); end
        step(); step();
    endtask

    task automatic test_ie_off();
        sts_we = 1; sts_wdata = 2'b00;
        step();
        sts_we = 0;
        int_req = 1; step(); int_req = 0;
        boundary = 1;
        step();
        boundary = 0;
        checks++; if (stall !== 1'b0 || cause_we !== 1'b0 || ie !== 1'b0) begin failures++; $display("FAIL ie_off_no_int got stall=%b we=%b ie=%b exp=0/0/0", stall, cause_we, ie); end
        exc_unimpl = 1; cur_pc = 32'h30; boundary = 1;
        step();
        exc_unimpl = 0; boundary = 0;
        checks++; if (cause_we !== 1'b1 || cause_code !== 2'b10 || epc_wdata !== 32'h30) begin failures++; $display("FAIL unimpl_ie_off got we=%b code=%b epc=%h exp=1/10/30", cause_we, cause_code, epc_wdata); end
        step(); step();
    endtask

    task automatic test_reset_mid_sequence();
        exc_sys = 1; cur_pc = 32'h14; boundary = 1;
        step();
        exc_sys = 0; boundary = 0;
        checks++; if (cause_we !== 1'b1 || stall !== 1'b1) begin failures++; $display("FAIL rst_pre_save got we=%b stall=%b exp=1/1", cause_we, stall); end
        rst = 1;
        step();
        rst = 0;
        checks++; if ({cause_we, epc_we, pc_we, stall, ie, exl} !== 6'b0) begin failures++; $display("FAIL rst_mid_outputs got=%b exp=000000", {cause_we, epc_we, pc_we, stall, ie, exl}); end
        checks++; if (cause_code !== 2'b00 || epc_wdata !== 32'h0 || pc_wdata !== 32'h0) begin failures++; $display("FAIL rst_mid_data got code=%b epc=%h pc=%h exp=00/0/0", cause_code, epc_wdata, pc_wdata); end
        checks++; if (dut.int_pend !== 1'b0) begin failures++; $display("FAIL rst_mid_pend got=%b exp=0", dut.int_pend); end
        step();
        checks++; if (pc_we !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rst_mid_no_vector got pc_we=%b stall=%b exp=0/0", pc_we, stall); end
    endtask

    task automatic test_eret_vs_exception();
        sts_we = 1; sts_wdata = 2'b11;
        step();
        sts_we = 0;
        eret = 1; exc_sys = 1; cur_pc = 32'h10; epc_q = 32'h60; boundary = 1;
        step();
        eret = 0; exc_sys = 0; boundary = 0;
        checks++; if ({cause_we, pc_we} !== 2'b10 || cause_code !== 2'b01 || epc_wdata !== 32'h10) begin failures++; $display("FAIL eret_exc_save got we=%b code=%b epc=%h exp=10/01/10", {cause_we, pc_we}, cause_code, epc_wdata); end
        step();
        checks++; if (pc_we !== 1'b1 || pc_wdata !== 32'h8) begin failures++; $display("FAIL eret_exc_vector got pc_we=%b pc=%h exp=1/8", pc_we, pc_wdata); end
        step();
        checks++; if (exl !== 1'b1 || stall !== 1'b0 || pc_we !== 1'b0) begin failures++; $display("FAIL eret_exc_done got exl=%b stall=%b pc_we=%b exp=1/0/0", exl, stall, pc_we); end
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_priority();
        test_masked_then_eret();
        test_ie_off();
        test_reset_mid_sequence();
        test_eret_vs_exception();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Exception/interrupt sequencer for the multi-cycle CPU's CP0 block.
- Arbitrates between the external interrupt and synchronous exception sources at instruction boundaries.
- Produces the 2-bit cause code that is zero-extended into the 32-bit Cause register.
- Sequences the Cause/EPC writes and the PC redirect to the handler vector, handles eret, and holds the Status IE/EXL bits.
- Stalls the main control FSM while a sequence is in flight.

Parameters:
VECTOR_ADDR, 32'h0000_0008, handler entry address loaded into PC on exception entry.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
int_req  input  1  external interrupt request (level).
boundary  input  1  main control at instruction-complete state; sampling strobe.
exc_ovf  input  1  arithmetic overflow on current instruction.
exc_unimpl  input  1  unimplemented/illegal opcode.
exc_sys  input  1  syscall executed.
eret  input  1  eret executed.
cur_pc  input  32  address of current instruction.
next_pc  input  32  address of following instruction.
epc_q  input  32  current EPC register contents.
sts_we  input  1  mtc0 write to Status.
sts_wdata  input  2  [0]=IE, [1]=EXL.
cause_code  output  2  cause to Cause register: 00 int, 01 sys, 10 unimpl, 11 ovf.
cause_we  output  1  Cause write enable.
epc_we  output  1  EPC write enable.
epc_wdata  output  32  value for EPC.
pc_we  output  1  PC override write enable.
pc_wdata  output  32  PC override value.
stall  output  1  holds main FSM.
ie  output  1  Status interrupt enable.
exl  output  1  Status exception level.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, int_pend=0, ie=0, exl=0, cause_code=00, epc_wdata=0, pc_wdata=0, all enables=0, stall=0.
- Reset asserted mid-sequence: IDLE at the next edge, no write pulses issued, and any pending interrupt is discarded.
- int_pend is set on any cycle with int_req=1. It is cleared only when an interrupt is taken.
- FSM states: IDLE, SAVE, VECTOR, RET.
- IDLE: acts only when boundary=1. Priority order, highest first:
  - exc_ovf (11)
  - exc_unimpl (10)
  - exc_sys (01)
  - interrupt (00), taken only if int_pend & ie & ~exl
  - eret
- Exception taken in IDLE (from IDLE go to SAVE):
  - Latch the winning code.
  - Latch epc_wdata: cur_pc for synchronous exceptions, next_pc for an interrupt.
  - stall=1.
- Eret taken in IDLE (from IDLE go to RET): stall=1.
- Exception and eret in the same cycle: the exception wins and eret is dropped.
- Synchronous exceptions are taken regardless of exl or ie.
- SAVE, 1 cycle:
  - cause_we=1, epc_we=1, exl<=1.
  - If the code is 00, clear int_pend.
  - Next state VECTOR.
- VECTOR, 1 cycle: pc_we=1, pc_wdata=VECTOR_ADDR, stall=1. Next state IDLE.
- RET, 1 cycle: pc_we=1, pc_wdata=epc_q, exl<=0, stall=1. Next state IDLE.
- stall=1 from the cycle after entry is decided through the last cycle of SAVE/VECTOR/RET, and drops with the return to IDLE.
- Latency: boundary-with-exception edge → cause_we/epc_we one cycle later → pc_we two cycles later.
- Enables (cause_we, epc_we, pc_we) are single-cycle pulses, never held.
- sts_we: honoured only in IDLE; ignored in other states.
  - If sts_we coincides with an exception decision, ie takes sts_wdata[0].
  - exl is then set by SAVE regardless of sts_wdata[1].
- boundary while stall=1 is ignored.
- int_req asserted while exl=1 stays pending and is taken at the first boundary after eret clears exl, provided ie=1.

Test Plan:
- Reset, then ie=1 via sts_we with sts_wdata=01; pulse int_req; boundary with next_pc=0x0000_0040 → cause_we/epc_we next cycle with cause_code=00 and epc_wdata=0x40; pc_we with pc_wdata=0x8 one cycle later; exl=1; int_pend cleared.
- boundary with exc_ovf=1, exc_sys=1, int_pend=1, cur_pc=0x24 → cause_code=11, epc_wdata=0x24, single interrupt-free sequence; int_pend stays 1.
- exl=1 and int_req=1 held; boundary with no exceptions → no sequence. Then eret with epc_q=0x44 → pc_we with pc_wdata=0x44 and exl=0. The next boundary takes the interrupt (cause_code=00).
- ie=0, int_req=1, boundary → no action, stall stays 0. Then exc_unimpl at boundary → cause_code=10, taken despite ie=0.
- Assert rst during SAVE → no pc_we pulse; all outputs return to reset values the next cycle; state is IDLE.
- eret and exc_sys at the same boundary with cur_pc=0x10 → exception path only (cause_code=01, epc_wdata=0x10, pc_wdata=0x8); exl stays 1.
